// File: rtl/shift_pkg.sv
// Shared types for the shift_reg_n serial shifter.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_t;

endpackage

// File: rtl/bit_counter.sv
// Down-counter tracking bits remaining in the current word; o_last flags cnt == 1.
module bit_counter #(
  parameter int WIDTH = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] r_cnt;

  // Clear wins over load, load wins over decrement.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(WIDTH);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/shift_reg_n.sv
// Full-duplex parallel-load shift register: transmits D serially while assembling
// the received word from Serial_In; supports gapless back-to-back words.
module shift_reg_n
  import shift_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Serial_In,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Rx_Valid,
  output logic             Busy,
  output logic             Underrun,
  output shift_state_t     Dbg_State
);

  // Handshake: a word transfers on an edge where Load_Valid && Load_Ready.
  // Load_Ready is high in IDLE, and on the final-bit strobe cycle in SHIFT
  // (combinational from Shift_En) so the next word streams with no gap.

  shift_state_t     r_state;
  shift_state_t     w_next_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;
  logic             w_shift;
  logic             w_final;
  logic             w_load;
  logic             w_dec;

  assign w_shift    = (r_state == SHIFT) && Shift_En;
  assign w_final    = w_shift && w_last;
  assign Load_Ready = (r_state == IDLE) || w_final;
  assign w_load     = Load_Valid && Load_Ready && !Clear;
  assign w_dec      = w_shift && !w_load && !Clear;

  assign Busy       = (r_state == SHIFT);
  assign Dbg_State  = r_state;

  always_comb begin
    w_shifted = r_sr;
    if (MSB_FIRST) begin
      w_shifted = {r_sr[WIDTH-2:0], Serial_In};
    end else begin
      w_shifted = {Serial_In, r_sr[WIDTH-1:1]};
    end
  end

  always_comb begin
    Shift_Out = 1'b0;
    if (r_state == SHIFT) begin
      Shift_Out = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
    end
  end

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .i_clear(Clear),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_last (w_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (Clear) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (Load_Valid) w_next_state = SHIFT;
        SHIFT:   if (w_final && !Load_Valid) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // A load on the final-bit cycle overrides the shift of sr; the received
  // word is still captured from the shifted value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sr     <= '0;
      Data_Out <= '0;
      Rx_Valid <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      Rx_Valid <= w_final && !Clear;
      Underrun <= (r_state == IDLE) && Shift_En && !Clear;
      if (!Clear) begin
        if (w_final) begin
          Data_Out <= w_shifted;
        end
        if (w_load) begin
          r_sr <= D;
        end else if (w_shift) begin
          r_sr <= w_shifted;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_n.sv
// Bench for shift_reg_n: MSB-first and LSB-first instances share inputs.
module tb_shift_reg_n;
  import shift_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         load_valid;
  logic [W-1:0] d;
  logic         shift_en;
  logic         serial_in;

  logic         m_load_ready, m_shift_out, m_rx_valid, m_busy, m_underrun;
  logic [W-1:0] m_data_out;
  shift_state_t m_state;
  logic         l_load_ready, l_shift_out, l_rx_valid, l_busy, l_underrun;
  logic [W-1:0] l_data_out;
  shift_state_t l_state;

  logic [W-1:0] exp_q[$];
  logic         exp_bit_q[$];
  logic [W-1:0] last_m;
  int           n_checks;
  int           n_fail;

  shift_reg_n #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .Clk(clk), .Reset_n(rst_n), .Clear(clear), .Load_Valid(load_valid),
    .Load_Ready(m_load_ready), .D(d), .Shift_En(shift_en), .Serial_In(serial_in),
    .Shift_Out(m_shift_out), .Data_Out(m_data_out), .Rx_Valid(m_rx_valid),
    .Busy(m_busy), .Underrun(m_underrun), .Dbg_State(m_state)
  );

  shift_reg_n #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(clk), .Reset_n(rst_n), .Clear(clear), .Load_Valid(load_valid),
    .Load_Ready(l_load_ready), .D(d), .Shift_En(shift_en), .Serial_In(serial_in),
    .Shift_Out(l_shift_out), .Data_Out(l_data_out), .Rx_Valid(l_rx_valid),
    .Busy(l_busy), .Underrun(l_underrun), .Dbg_State(l_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clear = 1'b0; load_valid = 1'b0; d = '0; shift_en = 1'b0; serial_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
    n_checks++; if (m_load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b expected 1", m_load_ready); end
    n_checks++; if (m_shift_out !== 1'b0) begin n_fail++; $display("FAIL reset_shift_out: got %b expected 0", m_shift_out); end
    n_checks++; if (m_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", m_data_out); end
    n_checks++; if ({m_rx_valid, m_underrun} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {m_rx_valid, m_underrun}); end
    n_checks++; if (m_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", m_state); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One full word with `gap` idle cycles before each strobe; checks the selected instance.
  task automatic run_word(input logic [W-1:0] word, input logic [W-1:0] si_bits,
                          input int gap, input bit msb);
    logic [W-1:0] rx;
    logic         eb;
    logic [W-1:0] ew;
    rx = word;
    for (int i = 0; i < W; i++) begin
      exp_bit_q.push_back(msb ? word[W-1-i] : word[i]);
      rx = msb ? {rx[W-2:0], si_bits[W-1-i]} : {si_bits[W-1-i], rx[W-1:1]};
    end
    exp_q.push_back(rx);
    load_valid = 1'b1; d = word; #1;
    n_checks++; if ((msb ? m_load_ready : l_load_ready) !== 1'b1) begin n_fail++; $display("FAIL word_load_ready: got 0 expected 1"); end
    tick();
    load_valid = 1'b0; d = '0;
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < gap; g++) tick();
      eb = exp_bit_q.pop_front();
      n_checks++; if ((msb ? m_shift_out : l_shift_out) !== eb) begin n_fail++; $display("FAIL word_bit%0d: got %b expected %b", i, msb ? m_shift_out : l_shift_out, eb); end
      n_checks++; if ((msb ? m_busy : l_busy) !== 1'b1) begin n_fail++; $display("FAIL word_busy%0d: got 0 expected 1", i); end
      shift_en = 1'b1; serial_in = si_bits[W-1-i]; #1;
      n_checks++; if ((msb ? m_load_ready : l_load_ready) !== (i == W-1)) begin n_fail++; $display("FAIL word_ready%0d: got %b expected %b", i, msb ? m_load_ready : l_load_ready, i == W-1); end
      tick();
      shift_en = 1'b0; serial_in = 1'b0;
      n_checks++; if ((msb ? m_rx_valid : l_rx_valid) !== (i == W-1)) begin n_fail++; $display("FAIL word_rx_valid%0d: got %b expected %b", i, msb ? m_rx_valid : l_rx_valid, i == W-1); end
    end
    ew = exp_q.pop_front();
    n_checks++; if ((msb ? m_data_out : l_data_out) !== ew) begin n_fail++; $display("FAIL word_data_out: got %h expected %h", msb ? m_data_out : l_data_out, ew); end
    n_checks++; if ((msb ? m_busy : l_busy) !== 1'b0) begin n_fail++; $display("FAIL word_busy_fall: got 1 expected 0"); end
    tick();
    n_checks++; if ((msb ? m_rx_valid : l_rx_valid) !== 1'b0) begin n_fail++; $display("FAIL word_rx_single: got 1 expected 0"); end
    n_checks++; if ((msb ? m_shift_out : l_shift_out) !== 1'b0) begin n_fail++; $display("FAIL word_idle_out: got 1 expected 0"); end
  endtask

  task automatic test_msb_word();
    run_word(8'hA5, 8'b1100_1010, 2, 1'b1);
  endtask

  task automatic test_lsb_word();
    run_word(8'h01, 8'hFF, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[2];
    logic         si[16];
    logic [W-1:0] rx;
    logic         eb;
    int           p1, p2;
    words[0] = 8'h3C; words[1] = 8'hC3;
    p1 = -1; p2 = -1;
    for (int j = 0; j < 16; j++) si[j] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 2; k++) begin
      rx = words[k];
      for (int i = 0; i < W; i++) begin
        exp_bit_q.push_back(words[k][W-1-i]);
        rx = {rx[W-2:0], si[k*W+i]};
      end
      exp_q.push_back(rx);
      last_m = rx;
    end
    load_valid = 1'b1; d = 8'h3C;
    tick();
    d = 8'hC3;
    for (int j = 0; j < 16; j++) begin
      if (j == W) load_valid = 1'b0;
      shift_en = 1'b1; serial_in = si[j];
      eb = exp_bit_q.pop_front();
      n_checks++; if (m_shift_out !== eb) begin n_fail++; $display("FAIL stream_bit%0d: got %b expected %b", j, m_shift_out, eb); end
      n_checks++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy%0d: got 0 expected 1", j); end
      tick();
      if (m_rx_valid === 1'b1) begin
        if (p1 < 0) p1 = j; else p2 = j;
      end
      n_checks++; if (m_rx_valid !== (j == 7 || j == 15)) begin n_fail++; $display("FAIL stream_rx%0d: got %b expected %b", j, m_rx_valid, j == 7 || j == 15); end
      if (j == 7 || j == 15) begin
        rx = exp_q.pop_front();
        n_checks++; if (m_data_out !== rx) begin n_fail++; $display("FAIL stream_data%0d: got %h expected %h", j, m_data_out, rx); end
      end
    end
    shift_en = 1'b0; serial_in = 1'b0;
    n_checks++; if (p2 - p1 !== 8) begin n_fail++; $display("FAIL stream_spacing: got %0d expected 8", p2 - p1); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy_end: got 1 expected 0"); end
    tick();
  endtask

  task automatic test_underrun();
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    n_checks++; if (m_underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_idle: got 0 expected 1"); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL underrun_idle_busy: got 1 expected 0"); end
    tick();
    n_checks++; if (m_underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_single: got 1 expected 0"); end
    n_checks++; if (m_data_out !== last_m) begin n_fail++; $display("FAIL underrun_data: got %h expected %h", m_data_out, last_m); end
    shift_en = 1'b1; load_valid = 1'b1; d = 8'h80;
    tick();
    shift_en = 1'b0; load_valid = 1'b0; d = '0;
    n_checks++; if (m_underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_with_load: got 0 expected 1"); end
    n_checks++; if (m_shift_out !== 1'b1) begin n_fail++; $display("FAIL underrun_first_bit_msb: got %b expected 1", m_shift_out); end
    n_checks++; if (l_shift_out !== 1'b0) begin n_fail++; $display("FAIL underrun_first_bit_lsb: got %b expected 0", l_shift_out); end
    n_checks++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL underrun_load_busy: got 0 expected 1"); end
    tick();
    n_checks++; if ({m_underrun, m_shift_out} !== 2'b01) begin n_fail++; $display("FAIL underrun_hold: got %b expected 01", {m_underrun, m_shift_out}); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (m_state !== IDLE) begin n_fail++; $display("FAIL underrun_clear_state: got %0d expected IDLE", m_state); end
  endtask

  task automatic test_clear_reset();
    load_valid = 1'b1; d = 8'h5A;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shift_en = 1'b1; serial_in = 1'($urandom_range(0, 1));
      tick();
    end
    shift_en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got 1 expected 0"); end
    n_checks++; if (m_load_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready: got 0 expected 1"); end
    n_checks++; if (m_data_out !== last_m) begin n_fail++; $display("FAIL clear_data: got %h expected %h", m_data_out, last_m); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (m_rx_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_rx%0d: got 1 expected 0", i); end
      tick();
    end
    load_valid = 1'b1; d = 8'hFF;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_en = 1'b1; serial_in = 1'b0;
      tick();
    end
    shift_en = 1'b0;
    n_checks++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got 0 expected 1"); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got 1 expected 0"); end
    n_checks++; if (m_shift_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_shift_out: got 1 expected 0"); end
    n_checks++; if (m_load_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got 0 expected 1"); end
    n_checks++; if (m_data_out !== 8'h00) begin n_fail++; $display("FAIL async_reset_data: got %h expected 00", m_data_out); end
    n_checks++; if ({m_rx_valid, m_underrun} !== 2'b00) begin n_fail++; $display("FAIL async_reset_pulses: got %b expected 00", {m_rx_valid, m_underrun}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_m   = '0;
    test_reset();
    test_msb_word();
    test_lsb_word();
    test_back_to_back();
    test_underrun();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised full-duplex shift register and the next generation of the audio-path 9-bit shifter. Takes a parallel word through a ready/valid load handshake and shifts it out serially, one bit per `Shift_En` strobe. It captures `Serial_In` into the vacated end and presents the completed received word with a one-cycle valid pulse. It sits between the codec/DAC serial interface (bit-clock enable from the clock-divider logic) and the sample-buffer control.

## Interface
- `WIDTH`, 16: word length in bits, ≥2.
- `MSB_FIRST`, 1: 1 = shift toward MSB (out at bit WIDTH-1, in at bit 0); 0 = reverse.
- `Clk` in 1: single clock; all state changes on rising edge.
- `Reset_n` in 1: reset is asynchronous and active-low.
- `Clear` in 1: synchronous abort to IDLE.
- `Load_Valid` in 1: parallel word on `D` offered.
- `Load_Ready` out 1: block can accept `D` this cycle.
- `D` in WIDTH: parallel transmit word.
- `Shift_En` in 1: one-cycle bit strobe.
- `Serial_In` in 1: receive bit, sampled on edges where a shift occurs.
- `Shift_Out` out 1: current transmit bit.
- `Data_Out` out WIDTH: last completed received word.
- `Rx_Valid` out 1: one-cycle pulse, `Data_Out` updated.
- `Busy` out 1: word in progress.
- `Underrun` out 1: one-cycle pulse, `Shift_En` seen while IDLE.

## Operation
- States: IDLE, SHIFT. Internal shift register `sr[WIDTH-1:0]`, bit counter `cnt` (0..WIDTH).
- IDLE: `Load_Ready`=1, `Busy`=0, `Shift_Out`=0.
  - `Load_Valid` loads `sr`<=`D` and `cnt`<=WIDTH, then moves to SHIFT.
  - `Shift_En` with no load produces an `Underrun` pulse; `sr` is unchanged.
  - `Load_Valid` and `Shift_En` in the same cycle: the load is taken, no shift occurs, and `Underrun` pulses.
- SHIFT: `Busy`=1. `Shift_Out` = `sr[WIDTH-1]` (MSB_FIRST) or `sr[0]`.
  - Each `Shift_En` shifts `sr` one place, inserts `Serial_In` at the opposite end, and decrements `cnt`.
  - Without `Shift_En`, everything holds.
- Final bit (`cnt`==1 and `Shift_En`): `Data_Out` <= shifted `sr` including this `Serial_In`. `Rx_Valid` pulses on the next cycle.
  - If `Load_Valid` is high in the same cycle, the new `D` loads, `cnt`<=WIDTH, and the block stays in SHIFT (gapless streaming).
  - Otherwise it returns to IDLE.
- `Load_Ready` = IDLE, or (SHIFT and `cnt`==1 and `Shift_En`). This is combinational from `Shift_En`. It is 0 at all other times in SHIFT; `Load_Valid` then has no effect.
- `Clear`: highest priority over load and shift.
  - Result: IDLE, `cnt`<=0, no `Rx_Valid`, `Data_Out` unchanged, `sr` unchanged.
  - `Clear` on the final-bit cycle suppresses the `Data_Out` update.
- Reset (`Reset_n`=0, any time including mid-word) gives: IDLE, `sr`=0, `cnt`=0, `Data_Out`=0, `Rx_Valid`=0, `Underrun`=0. `Busy`=0, `Shift_Out`=0, `Load_Ready`=1 follow from IDLE.

## Timing
- Load accepted at edge k: first bit is on `Shift_Out` after edge k, before any `Shift_En`.
- Bit n is presented until the edge carrying the n-th `Shift_En`. The next bit is valid after that edge.
- WIDTH strobes complete a word. `Rx_Valid` is high for exactly the cycle after the edge of the final strobe, and `Data_Out` is valid from that same cycle.
- Back-to-back `Shift_En` (every cycle) is legal. The minimum word time is WIDTH cycles, and streaming has zero gap.
- `Underrun` and `Rx_Valid` are registered pulses, 1 cycle wide, with no repeat unless re-triggered.

## Structure
- Package `shift_pkg`: `shift_state_t` enum {IDLE, SHIFT}.
- One sub-module, `bit_counter`: parametrised down-counter with load, decrement enable, and `last` (cnt==1) flag.
- Width of `cnt` is `$clog2(WIDTH+1)`.

## Test plan
- WIDTH=8, MSB_FIRST=1: load 0xA5, 8 strobes one per 3 cycles, `Serial_In` pattern 1,1,0,0,1,0,1,0 -> `Shift_Out` sequence 1,0,1,0,0,1,0,1; `Data_Out`=0xCA with a single `Rx_Valid` pulse; `Busy` falls.
- MSB_FIRST=0: load 0x01, 8 strobes, `Serial_In`=1 -> `Shift_Out` 1,0,0,0,0,0,0,0; `Data_Out`=0xFF.
- Streaming: `Shift_En` every cycle, `Load_Valid` held with 0x3C then 0xC3 -> 16 contiguous output bits 00111100 11000011; two `Rx_Valid` pulses 8 cycles apart; `Busy` never drops.
- `Shift_En` in IDLE, including simultaneous with `Load_Valid` -> `Underrun` pulse each time; after the simultaneous case, the first bit of the loaded word is still present.
- `Clear` after 5 of 8 bits -> IDLE next cycle, no `Rx_Valid`, `Data_Out` retains its previous value. Then `Reset_n` low mid-word -> all outputs at reset values immediately, without waiting for a `Clk` edge.
